fetch_queue: RTL

Instruction queue between the fetch stage and the decode pipeline register. It decouples PC generation and instruction fetch from decode stalls. Each fetched instruction (pc, instr, predicted next pc) is held in a small circular FIFO with valid/ready handshakes on both sides. A redirect from execute flushes all queued entries in one cycle.

---
 rtl/fetch_queue.sv | 87 ++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction queue between fetch and decode with single-cycle flush
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_pc,
  input  logic [31:0]      in_instr,
  input  logic [63:0]      in_pre_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [63:0]      out_pre_pc,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [159:0]     mem_q [DEPTH];
  logic [159:0]     head;
  logic             push, pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  // in_ready looks only at the registered count, so out_ready never reaches it
  assign in_ready  = ~full;
  assign out_valid = ~empty & ~flush;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  assign head       = mem_q[rd_ptr_q];
  assign out_pc     = out_valid ? head[159:96] : 64'd0;
  assign out_instr  = out_valid ? head[95:64]  : 32'd0;
  assign out_pre_pc = out_valid ? head[63:0]   : 64'd0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Flush only rewinds the pointers; stale entries stay in storage until overwritten
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {in_pc, in_instr, in_pre_pc};
    end
  end

endmodule
